// File: rtl/id_issue_buffer_pkg.sv
// Shared types for the decode-to-issue decoupling buffer.
// scoreboard_entry_t is a reduced stand-in for the core's scoreboard entry;
// id_issue_entry_t bundles it with the control-flow flag so both travel together.
package id_issue_buffer_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  fu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_imm;
    } scoreboard_entry_t;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
    } id_issue_entry_t;

endpackage

// File: rtl/id_issue_buffer.sv
// id_issue_buffer: small in-order FIFO between decode and the issue stage.
// Absorbs issue-side stalls so decode can keep going. Every buffered entry is
// unissued, so either flush input empties the whole buffer.
// Optional feature: define ID_ISSUE_BUF_BYPASS_EN for a zero-latency path
// through an empty buffer.
module id_issue_buffer
    import id_issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    flush_unissued_instr_i,
    input  scoreboard_entry_t       decoded_instr_i,
    input  logic                    decoded_instr_valid_i,
    input  logic                    is_ctrl_flow_i,
    output logic                    decoded_instr_ack_o,
    output scoreboard_entry_t       issue_instr_o,
    output logic                    issue_instr_valid_o,
    output logic                    is_ctrl_flow_o,
    input  logic                    issue_ack_i,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    id_issue_entry_t  entries [DEPTH];
    id_issue_entry_t  head;
    id_issue_entry_t  incoming;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             flush;
    logic             empty;
    logic             full;
    logic             head_valid;
    logic             write_en;
    logic             read_en;

    assign flush      = flush_i | flush_unissued_instr_i;
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign incoming   = {decoded_instr_i, is_ctrl_flow_i};
    assign head       = entries[rd_ptr];
    assign head_valid = ~empty & ~flush;
    assign count_o    = count;

    // A full buffer still accepts when the head leaves in the same cycle.
    assign decoded_instr_ack_o = decoded_instr_valid_i & ~flush & (~full | issue_ack_i);

    // Only stored entries are dequeued; a bypassed instruction never touches storage.
    assign read_en = head_valid & issue_ack_i;

`ifdef ID_ISSUE_BUF_BYPASS_EN
    logic bypass;

    assign bypass              = empty & ~flush;
    assign write_en            = decoded_instr_ack_o & ~(bypass & issue_ack_i);
    assign issue_instr_valid_o = bypass ? decoded_instr_valid_i : head_valid;
    assign issue_instr_o       = bypass ? decoded_instr_i : head.sbe;
    assign is_ctrl_flow_o      = bypass ? is_ctrl_flow_i : head.is_ctrl_flow;
`else
    assign write_en            = decoded_instr_ack_o;
    assign issue_instr_valid_o = head_valid;
    assign issue_instr_o       = head.sbe;
    assign is_ctrl_flow_o      = head.is_ctrl_flow;
`endif

    // Pointers and occupancy move together; flush returns everything to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (read_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({write_en, read_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is written only on enqueue and left untouched by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else if (write_en) begin
            entries[wr_ptr] <= incoming;
        end
    end

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed self-checking bench for id_issue_buffer (DEPTH = 2).
// Expectations follow ID_ISSUE_BUF_BYPASS_EN when that macro is defined.
module tb_id_issue_buffer;
    import id_issue_buffer_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic              flush_unissued_instr_i;
    scoreboard_entry_t decoded_instr_i;
    logic              decoded_instr_valid_i;
    logic              is_ctrl_flow_i;
    logic              decoded_instr_ack_o;
    scoreboard_entry_t issue_instr_o;
    logic              issue_instr_valid_o;
    logic              is_ctrl_flow_o;
    logic              issue_ack_i;
    logic [1:0]        count_o;

    int compared   = 0;
    int mismatched = 0;

    id_issue_buffer #(.DEPTH(2)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .flush_i                (flush_i),
        .flush_unissued_instr_i (flush_unissued_instr_i),
        .decoded_instr_i        (decoded_instr_i),
        .decoded_instr_valid_i  (decoded_instr_valid_i),
        .is_ctrl_flow_i         (is_ctrl_flow_i),
        .decoded_instr_ack_o    (decoded_instr_ack_o),
        .issue_instr_o          (issue_instr_o),
        .issue_instr_valid_o    (issue_instr_valid_o),
        .is_ctrl_flow_o         (is_ctrl_flow_o),
        .issue_ack_i            (issue_ack_i),
        .count_o                (count_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    function automatic scoreboard_entry_t mk(input logic [31:0] pc);
        scoreboard_entry_t e;
        e       = '0;
        e.pc    = pc;
        e.fu_op = pc[8:2];
        e.rd    = pc[6:2];
        return e;
    endfunction

    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic ctrl,
                                 input logic ack, input logic fl, input logic flu);
        decoded_instr_valid_i  = valid;
        decoded_instr_i        = mk(pc);
        is_ctrl_flow_i         = ctrl;
        issue_ack_i            = ack;
        flush_i                = fl;
        flush_unissued_instr_i = flu;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Directed sequence: reset, fill, pass-through, wrap, flush, bypass, mid-run reset.
    initial begin
        int sent;
        int issued;
        int cyc;

        rst_ni = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_count", 64'(count_o), 64'd0);
        rst_ni = 1'b1;
        #4;
        checkOutput("rst_valid", 64'(issue_instr_valid_o), 64'd0);
        checkOutput("rst_ack", 64'(decoded_instr_ack_o), 64'd0);
        checkOutput("rst_instr", 64'(issue_instr_o), 64'd0);
        checkOutput("rst_ctrl", 64'(is_ctrl_flow_o), 64'd0);
        checkOutput("rst_count2", 64'(count_o), 64'd0);
        tick();

        // Fill with issue_ack held low.
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        checkOutput("fill_ack0", 64'(decoded_instr_ack_o), 64'd1);
`ifdef ID_ISSUE_BUF_BYPASS_EN
        checkOutput("fill_valid0", 64'(issue_instr_valid_o), 64'd1);
        checkOutput("fill_instr0", 64'(issue_instr_o), 64'(mk(32'h80)));
`else
        checkOutput("fill_valid0", 64'(issue_instr_valid_o), 64'd0);
`endif
        tick();
        applyStimulus(1'b1, 32'h84, 1'b1, 1'b0, 1'b0, 1'b0);
        #4;
        checkOutput("fill_ack1", 64'(decoded_instr_ack_o), 64'd1);
        checkOutput("fill_count1", 64'(count_o), 64'd1);
        checkOutput("fill_valid1", 64'(issue_instr_valid_o), 64'd1);
        checkOutput("fill_instr1", 64'(issue_instr_o), 64'(mk(32'h80)));
        checkOutput("fill_ctrl1", 64'(is_ctrl_flow_o), 64'd0);
        tick();
        applyStimulus(1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        checkOutput("fill_ack2", 64'(decoded_instr_ack_o), 64'd0);
        checkOutput("fill_count2", 64'(count_o), 64'd2);
        checkOutput("fill_instr2", 64'(issue_instr_o), 64'(mk(32'h80)));
        tick();

        // Full pass-through: enqueue and dequeue together at count 2.
        applyStimulus(1'b1, 32'h88, 1'b0, 1'b1, 1'b0, 1'b0);
        #4;
        checkOutput("pass_ack", 64'(decoded_instr_ack_o), 64'd1);
        checkOutput("pass_valid", 64'(issue_instr_valid_o), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #4;
        checkOutput("pass_count", 64'(count_o), 64'd2);
        checkOutput("pass_instr", 64'(issue_instr_o), 64'(mk(32'h84)));
        checkOutput("pass_ctrl", 64'(is_ctrl_flow_o), 64'd1);
        tick();
        #4;
        checkOutput("drain_count1", 64'(count_o), 64'd1);
        checkOutput("drain_instr", 64'(issue_instr_o), 64'(mk(32'h88)));
        checkOutput("drain_ctrl", 64'(is_ctrl_flow_o), 64'd0);
        tick();
        #4;
        checkOutput("drain_count0", 64'(count_o), 64'd0);
        checkOutput("drain_valid", 64'(issue_instr_valid_o), 64'd0);
        tick();

        // Wrap-around: stream 8 instructions with issue_ack toggling.
        sent   = 0;
        issued = 0;
        cyc    = 0;
        while (issued < 8 && cyc < 60) begin
            applyStimulus(sent < 8, 32'(32'h100 + 4 * sent), sent[0], cyc[0] == 1'b0, 1'b0, 1'b0);
            #4;
            if (issue_instr_valid_o && issue_ack_i) begin
                checkOutput("wrap_order", 64'(issue_instr_o), 64'(mk(32'(32'h100 + 4 * issued))));
                checkOutput("wrap_ctrl", 64'(is_ctrl_flow_o), 64'(issued[0]));
                issued++;
            end
            if (decoded_instr_ack_o) sent++;
            tick();
            cyc++;
        end
        checkOutput("wrap_issued", 64'(issued), 64'd8);
        checkOutput("wrap_count", 64'(count_o), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush via flush_unissued_instr_i at full occupancy.
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flu_full", 64'(count_o), 64'd2);
        applyStimulus(1'b1, 32'h308, 1'b0, 1'b0, 1'b0, 1'b1);
        #4;
        checkOutput("flu_ack", 64'(decoded_instr_ack_o), 64'd0);
        checkOutput("flu_valid", 64'(issue_instr_valid_o), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        checkOutput("flu_count", 64'(count_o), 64'd0);
        checkOutput("flu_valid_after", 64'(issue_instr_valid_o), 64'd0);
        tick();

        // Same again via flush_i.
        applyStimulus(1'b1, 32'h310, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h314, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("fl_full", 64'(count_o), 64'd2);
        applyStimulus(1'b1, 32'h318, 1'b0, 1'b0, 1'b1, 1'b0);
        #4;
        checkOutput("fl_ack", 64'(decoded_instr_ack_o), 64'd0);
        checkOutput("fl_valid", 64'(issue_instr_valid_o), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        checkOutput("fl_count", 64'(count_o), 64'd0);
        tick();

        // Empty buffer with valid input and issue_ack high.
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0);
        #4;
        checkOutput("byp_ack", 64'(decoded_instr_ack_o), 64'd1);
`ifdef ID_ISSUE_BUF_BYPASS_EN
        checkOutput("byp_valid0", 64'(issue_instr_valid_o), 64'd1);
        checkOutput("byp_instr0", 64'(issue_instr_o), 64'(mk(32'h200)));
`else
        checkOutput("byp_valid0", 64'(issue_instr_valid_o), 64'd0);
`endif
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        #4;
`ifdef ID_ISSUE_BUF_BYPASS_EN
        checkOutput("byp_count1", 64'(count_o), 64'd0);
        checkOutput("byp_valid1", 64'(issue_instr_valid_o), 64'd0);
`else
        checkOutput("byp_count1", 64'(count_o), 64'd1);
        checkOutput("byp_valid1", 64'(issue_instr_valid_o), 64'd1);
        checkOutput("byp_instr1", 64'(issue_instr_o), 64'(mk(32'h200)));
`endif
        tick();
        #4;
        checkOutput("byp_count2", 64'(count_o), 64'd0);
        tick();

        // Asynchronous reset in the middle of operation.
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        checkOutput("mid_count_pre", 64'(count_o), 64'd1);
        checkOutput("mid_ctrl_pre", 64'(is_ctrl_flow_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        checkOutput("mid_count", 64'(count_o), 64'd0);
        checkOutput("mid_valid", 64'(issue_instr_valid_o), 64'd0);
        checkOutput("mid_instr", 64'(issue_instr_o), 64'd0);
        checkOutput("mid_ctrl", 64'(is_ctrl_flow_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        #4;
        checkOutput("mid_count_post", 64'(count_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
